// File: rtl/seq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_gen
//  Purpose  : Serialises a WIDTH-bit payload MSB first on a single-bit stream.
//             Only the top L bits are sent, where L comes from len. Each frame
//             is followed by a one-cycle done pulse. While the frame is sent,
//             the block keeps a saturating count of 1-bits and a flag that is
//             set when the last two bits sent were both 1.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    : payload width in bits
//    LW       : width of len, must satisfy 2**LW > WIDTH
//  Ports
//    clk      : in  rising-edge clock
//    reset    : in  asynchronous active-low reset
//    start    : in  frame request, accepted in IDLE or DONE
//    data     : in  payload, captured on accept
//    len      : in  bit count, captured on accept (0 or >WIDTH means WIDTH)
//    a        : out serial bit, MSB first
//    valid    : out a carries a frame bit
//    busy     : out frame being shifted out
//    done     : out one-cycle pulse after the last bit
//    ones_cnt : out 1-bits sent in current/last frame, saturating at 3
//    run2     : out last two bits sent in this frame were both 1
// ============================================================================
module seq_gen #(
   parameter int WIDTH = 8,
   parameter int LW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic [LW-1:0]    len,
   output logic             a,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [1:0]       ones_cnt,
   output logic             run2
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [LW-1:0] C_WIDTH_L = LW'(WIDTH);
   localparam logic [LW-1:0] C_ONE_L   = LW'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_sr;      // remaining bits; MSB is the next bit to send
   logic [LW-1:0]    r_cnt;     // bits still to send, including the one on a
   logic             r_a;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       r_ones;
   logic             r_run2;
   logic             r_last;    // previous bit of this frame, for run2

   logic [LW-1:0]    w_len_eff;

   // Zero and out-of-range lengths both select a full-width frame.
   assign w_len_eff = ((len == '0) || (len > C_WIDTH_L)) ? C_WIDTH_L : len;

   // The first bit is placed on a at the accepting edge itself, so the shift
   // register is loaded already advanced by one position. This gives the
   // one-cycle latency without any combinational path from inputs to a.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_sr    <= '0;
         r_cnt   <= '0;
         r_a     <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ones  <= 2'd0;
         r_run2  <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= ST_SHIFT;
                  r_a     <= data[WIDTH-1];
                  r_sr    <= {data[WIDTH-2:0], 1'b0};
                  r_cnt   <= w_len_eff;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_ones  <= 2'd0;
                  r_run2  <= 1'b0;
                  r_last  <= 1'b0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_SHIFT: begin
               // Account for the bit currently on a; it is sent this cycle.
               if (r_a && (r_ones != 2'd3))
                  r_ones <= r_ones + 2'd1;
               r_run2 <= r_a & r_last;
               r_last <= r_a;

               if (r_cnt == C_ONE_L) begin
                  r_state <= ST_DONE;
                  r_cnt   <= '0;
                  r_a     <= 1'b0;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_a   <= r_sr[WIDTH-1];
                  r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
                  r_cnt <= r_cnt - C_ONE_L;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_a     <= 1'b0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign a        = r_a;
   assign valid    = r_valid;
   assign busy     = r_busy;
   assign done     = r_done;
   assign ones_cnt = r_ones;
   assign run2     = r_run2;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_seq_gen
//  Purpose  : Self-checking bench for seq_gen. Expected bits and per-frame
//             results are queued when a frame is requested and compared as
//             the serial stream comes out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data  = 8'h00;
   logic [3:0] len   = 4'h0;
   logic       a, valid, busy, done, run2;
   logic [1:0] ones_cnt;

   seq_gen #(.WIDTH(8), .LW(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .data     (data),
      .len      (len),
      .a        (a),
      .valid    (valid),
      .busy     (busy),
      .done     (done),
      .ones_cnt (ones_cnt),
      .run2     (run2)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      logic b;
      logic first;
   } bit_t;

   typedef struct {
      int         nbits;
      logic [1:0] ones;
      logic       run2;
   } frame_t;

   bit_t   exp_bits[$];
   frame_t exp_frames[$];

   // Running model of ones_cnt/run2 driven by the expected bits.
   logic       mon_en = 1'b0;
   logic [1:0] m_ones = 2'd0;
   logic       m_run2 = 1'b0;
   logic       m_last = 1'b0;
   int         m_nbits = 0;
   bit_t       mb;
   frame_t     mf;

   task automatic push_frame(input logic [7:0] d, input logic [3:0] l);
      int         n;
      frame_t     f;
      bit_t       e;
      logic [1:0] o;
      logic       prev;
      n = ((l == 4'd0) || (l > 4'd8)) ? 8 : int'(l);
      o = 2'd0;
      prev = 1'b0;
      f.run2 = 1'b0;
      for (int i = 0; i < n; i++) begin
         e.b     = d[7-i];
         e.first = (i == 0);
         exp_bits.push_back(e);
         if (e.b && (o != 2'd3)) o = o + 2'd1;
         f.run2 = e.b & prev;
         prev   = e.b;
      end
      f.nbits = n;
      f.ones  = o;
      exp_frames.push_back(f);
   endtask

   // Called at a falling edge with the DUT idle; changes data/len right
   // after acceptance to show the frame was captured.
   task automatic send_frame(input logic [7:0] d, input logic [3:0] l);
      push_frame(d, l);
      data  = d;
      len   = l;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("latency_valid", valid, 1);
      data = 8'($urandom);
      len  = 4'($urandom);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (exp_frames.size() == 0 && !busy && !done) begin
            @(negedge clk);
            return;
         end
      end
      chk("timeout_frames_pending", exp_frames.size(), 0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (valid) begin
            chk("shift_busy", busy, 1);
            chk("shift_done", done, 0);
            if (exp_bits.size() == 0) begin
               chk("unexpected_bit", valid, 0);
            end else begin
               mb = exp_bits.pop_front();
               if (mb.first) begin
                  m_ones  = 2'd0;
                  m_run2  = 1'b0;
                  m_last  = 1'b0;
                  m_nbits = 0;
               end
               chk("a_bit", a, mb.b);
               chk("ones_during", ones_cnt, m_ones);
               chk("run2_during", run2, m_run2);
               if (mb.b && (m_ones != 2'd3)) m_ones = m_ones + 2'd1;
               m_run2 = mb.b & m_last;
               m_last = mb.b;
               m_nbits++;
            end
         end else begin
            chk("idle_a", a, 0);
            chk("idle_busy", busy, 0);
            chk("ones_hold", ones_cnt, m_ones);
            chk("run2_hold", run2, m_run2);
            if (done) begin
               if (exp_frames.size() == 0) begin
                  chk("unexpected_done", done, 0);
               end else begin
                  mf = exp_frames.pop_front();
                  chk("frame_len", m_nbits, mf.nbits);
                  chk("frame_ones", ones_cnt, mf.ones);
                  chk("frame_run2", run2, mf.run2);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      #12;
      chk("rst_a", a, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ones", ones_cnt, 0);
      chk("rst_run2", run2, 0);

      // Release reset and request immediately
      @(negedge clk);
      reset  = 1'b1;
      mon_en = 1'b1;
      send_frame(8'b1011_0000, 4'd4);
      wait_idle();

      send_frame(8'hAA, 4'd0);
      wait_idle();
      send_frame(8'hFF, 4'd15);
      wait_idle();
      send_frame(8'h80, 4'd1);
      wait_idle();

      // start held high: frames back to back, starts during SHIFT ignored
      push_frame(8'hC0, 4'd2);
      push_frame(8'hC0, 4'd2);
      push_frame(8'hC0, 4'd2);
      data  = 8'hC0;
      len   = 4'd2;
      start = 1'b1;
      repeat (7) @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Random frames
      for (int i = 0; i < 6; i++) begin
         send_frame(8'($urandom), 4'($urandom_range(0, 15)));
         wait_idle();
      end

      // Reset in the middle of a frame after three bits
      send_frame(8'hE7, 4'd8);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (exp_bits.size() == 5) break;
      end
      #1;
      reset = 1'b0;
      exp_bits.delete();
      exp_frames.delete();
      m_ones = 2'd0;
      m_run2 = 1'b0;
      m_last = 1'b0;
      #1;
      chk("arst_a", a, 0);
      chk("arst_valid", valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_ones", ones_cnt, 0);
      chk("arst_run2", run2, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      send_frame(8'h3C, 4'd0);
      wait_idle();

      chk("bits_pending", exp_bits.size(), 0);
      chk("frames_pending", exp_frames.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
